// File: rtl/fetch_sequencer.sv
// Program counter and run control in front of the instruction ROM: start/run/stop sequencing, branches, halt and overrun.
// Define FETCH_CYCLE_COUNT_EN to build the saturating RUN-cycle counter; otherwise cycle_count is tied to zero.
module fetch_sequencer #(
  parameter int         PC_WIDTH   = 11,
  parameter int         START_ADDR = 0,
  parameter logic [8:0] HALT_INST  = 9'h1FF,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8:0]           inst,
  input  logic                 branch_en,
  input  logic [PC_WIDTH:0]    target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 running,
  output logic                 done,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);
  localparam logic [PC_WIDTH-1:0] LAST_PC  = '1;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic                done_next, overrun_next;
  logic [PC_WIDTH-1:0] offset;
  logic                is_rel;

  assign offset  = target[PC_WIDTH-1:0];
  assign is_rel  = target[PC_WIDTH];
  assign running = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= START_PC;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      done    <= done_next;
      overrun <= overrun_next;
    end
  end

  // A taken branch outranks the overrun check, so branching from the last address never overruns.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    done_next    = done;
    overrun_next = overrun;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: if (!start) state_next = RUN;
      RUN: begin
        if (start) begin
          state_next = LOAD;
        end else if (inst == HALT_INST) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else if (branch_en) begin
          pc_next = is_rel ? (pc + offset) : offset;
        end else if (pc == LAST_PC) begin
          state_next   = DONE;
          done_next    = 1'b1;
          overrun_next = 1'b1;
        end else begin
          pc_next = pc + PC_WIDTH'(1);
        end
      end
      DONE: if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
    // Every path into or through LOAD re-arms the program at the start address.
    if (state_next == LOAD) begin
      pc_next      = START_PC;
      done_next    = 1'b0;
      overrun_next = 1'b0;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || state_next == LOAD) begin
      cnt <= '0;
    end else if (state == RUN && cnt != '1) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  assign cycle_count = cnt;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural model pushes expected outputs per cycle, popped and compared after each edge.
module tb_fetch_sequencer;

  localparam int         PW   = 11;
  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] NOP  = 9'h000;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, branch_en = 1'b0;
  logic [PW:0]   target = '0;
  logic [8:0]    inst, inst4;
  logic [PW-1:0] pc, pc4;
  logic          running, done, overrun, running4, done4, overrun4;
  logic [15:0]   cycle_count;
  logic [3:0]    cycle_count4;
  logic [8:0]    rom [0:2047];

  assign inst  = rom[pc];
  assign inst4 = rom[pc4];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .inst(inst), .branch_en(branch_en),
    .target(target), .pc(pc), .running(running), .done(done), .overrun(overrun),
    .cycle_count(cycle_count)
  );

  fetch_sequencer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .inst(inst4), .branch_en(branch_en),
    .target(target), .pc(pc4), .running(running4), .done(done4), .overrun(overrun4),
    .cycle_count(cycle_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pc;
    logic          running;
    logic          done;
    logic          overrun;
    logic [15:0]   cnt;
    logic [3:0]    cnt4;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Model state: 0 idle, 1 load, 2 run, 3 done
  int            m_state = 0;
  logic [PW-1:0] m_pc = '0;
  logic          m_done = 1'b0, m_ovr = 1'b0;
  int            m_cnt = 0;

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task modelLoad();
    m_state = 1; m_pc = '0; m_done = 1'b0; m_ovr = 1'b0; m_cnt = 0;
  endtask

  task applyStimulus(input logic r, input logic s, input logic b, input logic [PW:0] t);
    exp_t e;
    reset = r; start = s; branch_en = b; target = t;
    if (r) begin
      m_state = 0; m_pc = '0; m_done = 1'b0; m_ovr = 1'b0; m_cnt = 0;
    end else begin
      case (m_state)
        0: if (s) modelLoad();
        1: if (s) modelLoad(); else m_state = 2;
        2: begin
          if (s) modelLoad();
          else begin
            m_cnt++;
            if (rom[m_pc] == HALT) begin
              m_state = 3; m_done = 1'b1;
            end else if (b) begin
              if (t[PW]) m_pc = m_pc + t[PW-1:0];
              else       m_pc = t[PW-1:0];
            end else if (m_pc == 11'h7FF) begin
              m_state = 3; m_done = 1'b1; m_ovr = 1'b1;
            end else begin
              m_pc = m_pc + 11'd1;
            end
          end
        end
        default: if (s) modelLoad();
      endcase
    end
    e.pc = m_pc; e.running = (m_state == 2); e.done = m_done; e.overrun = m_ovr;
`ifdef FETCH_CYCLE_COUNT_EN
    e.cnt  = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e.cnt4 = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
`else
    e.cnt  = '0;
    e.cnt4 = '0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput("pc", 32'(pc), 32'(e.pc));
    checkOutput("running", 32'(running), 32'(e.running));
    checkOutput("done", 32'(done), 32'(e.done));
    checkOutput("overrun", 32'(overrun), 32'(e.overrun));
    checkOutput("cycle_count", 32'(cycle_count), 32'(e.cnt));
    checkOutput("pc_w4", 32'(pc4), 32'(e.pc));
    checkOutput("cycle_count_w4", 32'(cycle_count4), 32'(e.cnt4));
  endtask

  task tick(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  task runUntilPc(input logic [PW-1:0] want);
    for (int i = 0; i < 100 && m_pc != want; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("reach_pc", 32'(pc), 32'(want));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = NOP;
    rom[5] = HALT;

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h123);
    checkOutput("reset_pc", 32'(pc), 32'h0);
    checkOutput("reset_running", 32'(running), 32'h0);

    // Basic program: NOPs at 0..4, halt at 5
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick(10);
    checkOutput("halt_pc", 32'(pc), 32'h5);
    checkOutput("halt_done", 32'(done), 32'h1);
`ifdef FETCH_CYCLE_COUNT_EN
    checkOutput("halt_cnt", 32'(cycle_count), 32'd6);
`else
    checkOutput("cnt_off", 32'(cycle_count), 32'd0);
`endif

    // Absolute then relative branch
    rom[5] = NOP;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick(1);
    runUntilPc(11'h003);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h040);
    checkOutput("br_abs", 32'(pc), 32'h040);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'hFFE);
    checkOutput("br_rel", 32'(pc), 32'h03E);

    // Halt and branch together: halt wins; DONE ignores branches
    rom[11'h041] = HALT;
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h100);
    checkOutput("hb_pc", 32'(pc), 32'h041);
    checkOutput("hb_done", 32'(done), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h010);
    checkOutput("done_hold_pc", 32'(pc), 32'h041);

    // Restart pulse in the middle of RUN
    rom[11'h041] = NOP;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick(4);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("rs_pc", 32'(pc), 32'h0);
    checkOutput("rs_running", 32'(running), 32'h0);
    checkOutput("rs_done", 32'(done), 32'h0);
    tick(1);

    // Relative wrap from the last address does not overrun
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h7FF);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h802);
    checkOutput("wrap_pc", 32'(pc), 32'h001);
    checkOutput("wrap_ovr", 32'(overrun), 32'h0);
    checkOutput("wrap_done", 32'(done), 32'h0);

    // Run off the top of memory
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h7F0);
    for (int i = 0; i < 40 && !m_done; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("ovr_pc", 32'(pc), 32'h7FF);
    checkOutput("ovr_done", 32'(done), 32'h1);
    checkOutput("ovr_flag", 32'(overrun), 32'h1);
`ifdef FETCH_CYCLE_COUNT_EN
    checkOutput("sat_cnt4", 32'(cycle_count4), 32'hF);
`else
    checkOutput("cnt4_off", 32'(cycle_count4), 32'h0);
`endif

    // Reset mid-RUN wins over start and branch
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    tick(4);
    applyStimulus(1'b1, 1'b1, 1'b1, 12'h040);
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_running", 32'(running), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick(2);

    // Random traffic against the model over a ROM seeded with halts
    for (int i = 0; i < 2048; i++) rom[i] = ($urandom_range(0, 15) == 0) ? HALT : NOP;
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, 12'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and run-control stage that sits directly upstream of the instruction ROM and the control decoder. It turns the external `start` strobe into a clean run/stop sequence, owns the PC (sequential increment, absolute and relative branch redirect), detects the halt instruction and overrun, and drives the top-level `done` flag. An optional cycle counter reports execution length for benches.

## Interface
Parameters:
- `PC_WIDTH`, 11, PC width in bits; the branch target is `PC_WIDTH+1` bits.
- `START_ADDR`, 0, PC value loaded while `start` is high.
- `HALT_INST`, 9'h1FF, instruction word that ends the program.
- `CNT_WIDTH`, 16, cycle counter width.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level; high = load/hold; falling edge begins execution.
- `inst`  in  9  current instruction word from the ROM at `pc`; combinational feedback.
- `branch_en`  in  1  take a branch this cycle.
- `target`  in  `PC_WIDTH+1`  bit `PC_WIDTH` = 0 → absolute address `target[PC_WIDTH-1:0]`; = 1 → relative, signed offset `target[PC_WIDTH-1:0]`.
- `pc`  out  `PC_WIDTH`  current fetch address.
- `running`  out  1  high in RUN; qualifies `inst` for the control decoder.
- `done`  out  1  program finished, halted or overran.
- `overrun`  out  1  finished by running off the top of memory.
- `cycle_count`  out  `CNT_WIDTH`  RUN cycles executed (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset → IDLE.
- IDLE: `start`=1 → LOAD. Otherwise stay.
- LOAD: `pc`=`START_ADDR`, `done`=0, `overrun`=0, counter cleared; stay while `start`=1; `start`=0 → RUN.
- RUN, evaluated in priority order each cycle:
  1. `start`=1 → LOAD (restart; abandons program).
  2. `inst`==`HALT_INST` → DONE, `pc` held.
  3. `branch_en`=1 → `pc` ← absolute target, or `pc + sext(offset)` mod 2^`PC_WIDTH`.
  4. `pc`==2^`PC_WIDTH`−1 → DONE, `overrun`←1, `pc` held.
  5. else `pc` ← `pc`+1.
- Branching from the last address is legal and does not overrun. Relative targets wrap modulo 2^`PC_WIDTH`; no error.
- DONE: `done`=1, `pc` frozen; `branch_en`/`inst` ignored; `start`=1 → LOAD.
- `branch_en` outside RUN is ignored.

## Timing
- Reset values: `pc`=`START_ADDR`, `running`=0, `done`=0, `overrun`=0, `cycle_count`=0, state IDLE.
- All outputs are registered except `running`, which is decoded from the state register.
- `pc` update latency: 1 cycle. A branch asserted in cycle N puts the target on `pc` at N+1.
- Halt fetched in cycle N: `done`=1 from N+1; `pc` still points at the halt instruction.
- Start: `start` low first sampled at edge N puts the block in RUN from N+1 with `pc`=`START_ADDR`, so the first instruction executes in cycle N+1.
- Reset asserted mid-RUN returns to IDLE on the next edge regardless of other inputs.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined: `cycle_count` increments once per RUN cycle, including the halt cycle. It saturates at all-ones, clears in LOAD and reset, and holds in DONE/IDLE.
- Not defined: `cycle_count` is tied to 0 and no counter logic is built.

## Test plan
- Reset then `start` high 3 cycles, then low; ROM holds NOPs at 0–4 and `HALT_INST` at 5 → `pc` steps 0..5, `done` rises the cycle after `pc`=5, `pc` stays 5, `cycle_count`=6.
- At `pc`=3, `branch_en`=1 with `target`=12'h040 → next `pc`=0x040. At `pc`=0x040, `target`=12'hFFE (relative −2) → next `pc`=0x03E.
- Relative wrap: at `pc`=0x7FF, `branch_en`=1, `target`=12'h802 (+2) → next `pc`=0x001, no overrun.
- No halt: NOPs up to 0x7FF → `done`=1 and `overrun`=1 after `pc`=0x7FF, `pc` held at 0x7FF.
- Corner cases:
  - Halt and `branch_en` in the same cycle → DONE, branch ignored.
  - `start` pulsed during RUN → LOAD, `pc`=`START_ADDR`, `done`=0.
  - `reset` mid-RUN → all outputs return to reset values.
- Without `FETCH_CYCLE_COUNT_EN`, `cycle_count` stays 0. With `CNT_WIDTH`=4 and a 20-cycle program, `cycle_count` saturates at 15.
